sram_like_resp: RTL and testbench

Responder end of the SRAM-like req/addr_ok/data_ok interface that the fetch and memory stages drive. It accepts address handshakes, performs word reads and byte-strobed writes on an internal memory array, and returns in-order data_ok/rdata responses after a configurable latency. Optional pseudo-random back-pressure exercises initiator stall and cancel paths. It serves as the instruction/data memory model in the core testbench and as the baseline for the later AXI bridge.

---
 rtl/sram_like_resp.sv | 192 +++++++++++++++++++
 tb/tb_sram_like_resp.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_resp.sv
// -----------------------------------------------------------------------------
// sram_like_resp
//
// Responder end of the SRAM-like req/addr_ok/data_ok interface. It accepts
// address handshakes, performs word reads and byte-strobed writes on an
// internal memory array, and returns in-order data_ok/rdata responses after a
// fixed latency. An optional LFSR-driven stall injects pseudo-random
// back-pressure on both addr_ok and data_ok.
//
// Parameters:
//   AW        word-index width; the memory holds 2**AW 32-bit words
//   RESP_LAT  cycles from the address handshake to the earliest data_ok (1..15)
//   OUTST     maximum accepted-but-unanswered transactions (power of 2)
//   LFSR_SEED nonzero reset value of the stall LFSR
//
// Ports:
//   clk       clock
//   resetn    synchronous active-low reset
//   req       initiator request valid
//   wr        1 = write, 0 = read
//   size      transfer size (reads always return the full word)
//   wstrb     byte write strobes, used when wr = 1
//   addr      byte address; the word index is addr[AW+1:2]
//   wdata     write data
//   stall_en  enables random back-pressure on addr_ok and data_ok
//   addr_ok   address handshake accept (combinational)
//   data_ok   response valid, one cycle per accepted transaction
//   rdata     read data, qualified by data_ok (0 otherwise)
// -----------------------------------------------------------------------------
module sram_like_resp #(
  parameter int          AW        = 12,
  parameter int          RESP_LAT  = 2,
  parameter int          OUTST     = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall_en,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  // A single-entry FIFO still needs a 1-bit pointer to stay legal.
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int OW = $clog2(OUTST) + 1;

  localparam logic [3:0]    CNT_LOAD = 4'(RESP_LAT - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(OUTST);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTST - 1);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0]   mem       [2**AW];
  logic [31:0]   fifo_data [OUTST];
  logic [3:0]    fifo_cnt  [OUTST];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic [15:0]   lfsr;

  // ---------------------------------------------------------------------------
  // Derived control
  // ---------------------------------------------------------------------------
  logic [AW-1:0] idx;
  logic          full;
  logic          empty;
  logic          a_stall;
  logic          d_stall;
  logic          push;
  logic          pop;
  logic [31:0]   push_data;
  logic [31:0]   head_data;
  logic [3:0]    head_cnt;
  logic          lfsr_fb;

  // The byte offset, out-of-range upper address bits and size carry no
  // information for this responder: the index wraps and reads are full-word.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

  assign idx     = addr[AW+1:2];
  assign full    = (occ == OCC_FULL);
  assign empty   = (occ == '0);
  assign a_stall = stall_en & lfsr[0];
  assign d_stall = stall_en & lfsr[1];

  assign head_data = fifo_data[rd_ptr];
  assign head_cnt  = fifo_cnt[rd_ptr];

  // Both handshakes are masked while in reset so that responses still sitting
  // in the FIFO at the moment reset is asserted are dropped, never delivered.
  // A full FIFO blocks accept even when the head pops in the same cycle.
  assign addr_ok = resetn & req & ~full & ~a_stall;
  assign data_ok = resetn & ~empty & (head_cnt == 4'd0) & ~d_stall;
  assign rdata   = data_ok ? head_data : 32'h0;

  assign push = req & addr_ok;
  assign pop  = data_ok;

  // A read captures the word as it stands before this edge; any write accepted
  // earlier has already landed, so reads always observe prior writes.
  assign push_data = wr ? 32'h0 : mem[idx];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stall LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifting right every cycle.
  // ---------------------------------------------------------------------------
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array: not reset, so contents survive a reset. Only accepted writes
  // update it, byte lane by byte lane.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO payload. Stale slots are never observed because occupancy
  // gates data_ok, so the payload needs no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO control. Every nonzero countdown ticks each cycle regardless
  // of its position, so an entry that reaches the head late is already ripe.
  // The load on push is written after the decrement loop so it takes priority
  // for the slot being filled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < OUTST; i++) begin
        fifo_cnt[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < OUTST; i++) begin
        if (fifo_cnt[i] != 4'd0) begin
          fifo_cnt[i] <= fifo_cnt[i] - 4'd1;
        end
      end

      if (push) begin
        fifo_cnt[wr_ptr] <= CNT_LOAD;
        wr_ptr           <= ptr_next(wr_ptr);
      end

      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end

      unique case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_resp.sv
// -----------------------------------------------------------------------------
// tb_sram_like_resp
//
// Self-checking bench for sram_like_resp. A behavioural model tracks the
// memory contents and the queue of accepted-but-unanswered transactions (each
// stamped with its acceptance cycle) and is compared against the DUT on every
// falling edge. Directed sequences pin latency, byte strobes, FIFO full
// behaviour, read-after-write and reset with literal expectations; a
// randomized sequence with back-pressure enabled finishes the run.
// -----------------------------------------------------------------------------
module tb_sram_like_resp;

  localparam int AW       = 12;
  localparam int RESP_LAT = 2;
  localparam int OUTST    = 2;
  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic        clk      = 1'b0;
  logic        resetn   = 1'b0;
  logic        req      = 1'b0;
  logic        wr       = 1'b0;
  logic [1:0]  size     = 2'b10;
  logic [3:0]  wstrb    = 4'h0;
  logic [31:0] addr     = 32'h0;
  logic [31:0] wdata    = 32'h0;
  logic        stall_en = 1'b0;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } pend_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } resp_t;

  pend_t       mq[$];
  resp_t       resp_log[$];
  int          hs_count   = 0;
  int          resp_count = 0;
  logic [31:0] ref_mem [0:(1<<AW)-1];

  int          m_n;
  bit          m_full;
  bit          m_ready;
  logic [AW-1:0] m_idx;
  logic [31:0] m_data;

  sram_like_resp #(
    .AW        (AW),
    .RESP_LAT  (RESP_LAT),
    .OUTST     (OUTST),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .wstrb    (wstrb),
    .addr     (addr),
    .wdata    (wdata),
    .stall_en (stall_en),
    .addr_ok  (addr_ok),
    .data_ok  (data_ok),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model and compare process. Inputs are stable at the falling edge, so the
  // values seen here are exactly those the next rising edge will act on.
  always @(negedge clk) begin
    if (!resetn) begin
      checkOutput("reset_addr_ok", 32'(addr_ok), 32'h0);
      checkOutput("reset_data_ok", 32'(data_ok), 32'h0);
      checkOutput("reset_rdata", rdata, 32'h0);
      mq.delete();
    end else begin
      m_n     = mq.size();
      m_full  = (m_n == OUTST);
      m_ready = 1'b0;
      if (m_n > 0) begin
        m_ready = ((cyc - mq[0].acc) >= RESP_LAT);
      end

      if (!stall_en) begin
        checkOutput("addr_ok", 32'(addr_ok), 32'(req & ~m_full));
        checkOutput("data_ok_timing", 32'(data_ok), 32'(m_ready));
      end else begin
        checkOutput("addr_ok_legal", 32'(addr_ok & (~req | m_full)), 32'h0);
        checkOutput("data_ok_legal", 32'(data_ok & ~m_ready), 32'h0);
      end

      if (data_ok && m_n > 0) begin
        checkOutput("rdata", rdata, mq[0].data);
        resp_log.push_back('{cyc, rdata});
        resp_count++;
        void'(mq.pop_front());
      end else if (!data_ok) begin
        checkOutput("rdata_idle", rdata, 32'h0);
      end

      if (req && addr_ok) begin
        m_idx  = addr[AW+1:2];
        m_data = wr ? 32'h0 : ref_mem[m_idx];
        if (wr) begin
          for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) ref_mem[m_idx][8*i +: 8] = wdata[8*i +: 8];
          end
        end
        mq.push_back('{m_data, cyc});
        hs_count++;
      end
    end
    cyc++;
  end

  // Tasks are entered and left just after a rising edge.
  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one transaction and holds it until accepted; reports the
  // acceptance cycle and how many cycles it had to wait. req stays high on
  // return so back-to-back calls form a continuous request stream.
  task automatic applyStimulus(input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s,
                               output int acc_cyc, output int waits);
    int start;
    req   = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    size  = 2'($urandom_range(0, 3));
    start = cyc;
    waits = 0;
    forever begin
      @(negedge clk);
      if (addr_ok) break;
      if (waits >= 200) begin
        checkOutput("handshake_timeout", 32'(waits), 32'h0);
        break;
      end
      waits++;
      @(posedge clk);
      #1;
    end
    acc_cyc = start + waits;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n;
    req = 1'b0;
    n   = 0;
    while (mq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (mq.size() != 0) begin
      checkOutput("drain_timeout", 32'(mq.size()), 32'h0);
    end
    idle(2);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int aw, ar, a1, a2, a3, nw, nr, n1, n2, n3;
    int hs0, resp0;
    logic [31:0] ra;

    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    checkOutput("post_reset_addr_ok", 32'(addr_ok), 32'h0);
    checkOutput("post_reset_data_ok", 32'(data_ok), 32'h0);
    checkOutput("post_reset_rdata", rdata, 32'h0);

    // Full-word write, then read back.
    resp_log.delete();
    applyStimulus(1'b1, BASE, 32'h1234_5678, 4'hF, aw, nw);
    checkOutput("t1_wr_no_wait", 32'(nw), 32'h0);
    applyStimulus(1'b0, BASE, 32'h0, 4'h0, ar, nr);
    checkOutput("t1_rd_no_wait", 32'(nr), 32'h0);
    idle(6);
    checkOutput("t1_resp_count", 32'(resp_log.size()), 32'd2);
    if (resp_log.size() == 2) begin
      checkOutput("t1_wr_latency", 32'(resp_log[0].cyc - aw), 32'd2);
      checkOutput("t1_wr_rdata", resp_log[0].data, 32'h0);
      checkOutput("t1_rd_latency", 32'(resp_log[1].cyc - ar), 32'd2);
      checkOutput("t1_rd_rdata", resp_log[1].data, 32'h1234_5678);
    end

    // Partial write over the previous word.
    resp_log.delete();
    applyStimulus(1'b1, BASE, 32'hAABB_CCDD, 4'b0101, aw, nw);
    applyStimulus(1'b0, BASE, 32'h0, 4'h0, ar, nr);
    idle(6);
    checkOutput("t2_resp_count", 32'(resp_log.size()), 32'd2);
    if (resp_log.size() == 2) begin
      checkOutput("t2_rd_rdata", resp_log[1].data, 32'h12BB_56DD);
    end

    // Three back-to-back reads against a two-deep FIFO.
    applyStimulus(1'b1, BASE + 32'h4, 32'h1111_1111, 4'hF, aw, nw);
    applyStimulus(1'b1, BASE + 32'h8, 32'h2222_2222, 4'hF, aw, nw);
    idle(6);
    resp_log.delete();
    applyStimulus(1'b0, BASE,         32'h0, 4'h0, a1, n1);
    applyStimulus(1'b0, BASE + 32'h4, 32'h0, 4'h0, a2, n2);
    applyStimulus(1'b0, BASE + 32'h8, 32'h0, 4'h0, a3, n3);
    idle(8);
    checkOutput("t3_first_wait", 32'(n1), 32'h0);
    checkOutput("t3_second_wait", 32'(n2), 32'h0);
    checkOutput("t3_third_wait", 32'(n3), 32'd1);
    checkOutput("t3_resp_count", 32'(resp_log.size()), 32'd3);
    if (resp_log.size() == 3) begin
      checkOutput("t3_reaccept_cycle", 32'(a3 - resp_log[0].cyc), 32'd1);
      checkOutput("t3_order0", resp_log[0].data, 32'h12BB_56DD);
      checkOutput("t3_order1", resp_log[1].data, 32'h1111_1111);
      checkOutput("t3_order2", resp_log[2].data, 32'h2222_2222);
    end

    // Read accepted on the cycle right after a write to the same word.
    resp_log.delete();
    applyStimulus(1'b1, BASE + 32'h10, 32'hCAFE_F00D, 4'hF, aw, nw);
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'h0, ar, nr);
    idle(6);
    checkOutput("t4_back_to_back", 32'(ar - aw), 32'd1);
    checkOutput("t4_resp_count", 32'(resp_log.size()), 32'd2);
    if (resp_log.size() == 2) begin
      checkOutput("t4_rd_rdata", resp_log[1].data, 32'hCAFE_F00D);
    end

    // Reset with two reads outstanding.
    resp_log.delete();
    applyStimulus(1'b0, BASE,          32'h0, 4'h0, a1, n1);
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'h0, a2, n2);
    req    = 1'b0;
    resetn = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    idle(4);
    checkOutput("t5_dropped", 32'(resp_log.size()), 32'h0);
    applyStimulus(1'b0, BASE + 32'h10, 32'h0, 4'h0, ar, nr);
    idle(6);
    checkOutput("t5_one_resp", 32'(resp_log.size()), 32'd1);
    if (resp_log.size() == 1) begin
      checkOutput("t5_retained", resp_log[0].data, 32'hCAFE_F00D);
    end

    // Randomized traffic with back-pressure.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, aw, nw);
    end
    waitDrain();
    stall_en = 1'b1;
    hs0      = hs_count;
    resp0    = resp_count;
    for (int i = 0; i < 200; i++) begin
      ra       = $urandom;
      ra[13:2] = 12'($urandom_range(0, 7));
      applyStimulus(1'($urandom_range(0, 1)), ra, $urandom,
                    4'($urandom_range(0, 15)), aw, nw);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    waitDrain();
    checkOutput("t6_accepts", 32'(hs_count - hs0), 32'd200);
    checkOutput("t6_resp_eq_accepts", 32'(resp_count - resp0),
                32'(hs_count - hs0));
    stall_en = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
